// File: rtl/spi_lcd_rx.sv
// ============================================================================
// Module   : spi_lcd_rx
// Brief    : SPI (mode 0) LCD command/pixel sniffer. Assembles bytes, decodes
//            CASET/PASET/RAMWR and emits RGB565 pixels with window cursor.
//            Optional macro SPI_LCD_RX_STATS_EN adds the o_pix_count port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_lcd_rx #(
    parameter int WIDTH  = 240,
    parameter int HEIGHT = 320
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_sclk,
    input  logic                      i_mosi,
    input  logic                      i_cs,
    input  logic                      i_dc,
    output logic [7:0]                o_byte,
    output logic                      o_byte_dc,
    output logic                      o_byte_valid,
    output logic                      o_pix_valid,
    output logic [$clog2(WIDTH)-1:0]  o_pix_x,
    output logic [$clog2(HEIGHT)-1:0] o_pix_y,
    output logic [15:0]               o_pix_data
`ifdef SPI_LCD_RX_STATS_EN
    ,
    output logic [31:0]               o_pix_count
`endif
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam logic [15:0] c_xmax = 16'(WIDTH - 1);
    localparam logic [15:0] c_ymax = 16'(HEIGHT - 1);

    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_caset    = 3'd1;
    localparam logic [2:0] c_st_paset    = 3'd2;
    localparam logic [2:0] c_st_ramwr_hi = 3'd3;
    localparam logic [2:0] c_st_ramwr_lo = 3'd4;
    localparam logic [2:0] c_st_ignore   = 3'd5;

    // sclk shift: [0]=meta, [1]=synced, [2]=previous synced (edge detect)
    logic [2:0]    r_sclk_sh;
    logic [1:0]    r_mosi_sh, r_cs_sh, r_dc_sh;
    logic [2:0]    r_bit_cnt;
    logic [6:0]    r_shift;
    logic [7:0]    r_byte;
    logic          r_byte_dc, r_byte_valid;
    logic [2:0]    r_state, w_state_nxt;
    logic [1:0]    r_idx;
    logic [23:0]   r_par;
    logic [7:0]    r_pix_hi;
    logic [XW-1:0] r_xs, r_xe, r_cx, r_pix_x;
    logic [YW-1:0] r_ys, r_ye, r_cy, r_pix_y;
    logic [15:0]   r_pix_data;
    logic          r_pix_valid;
    logic          w_sclk_rise, w_pix_fire, w_win_done;
    logic [XW-1:0] w_xs_c, w_xe_c, w_xe_fix;
    logic [YW-1:0] w_ys_c, w_ye_c, w_ye_fix;

    function automatic logic [XW-1:0] clamp_x(input logic [15:0] v);
        return (v > c_xmax) ? c_xmax[XW-1:0] : v[XW-1:0];
    endfunction

    function automatic logic [YW-1:0] clamp_y(input logic [15:0] v);
        return (v > c_ymax) ? c_ymax[YW-1:0] : v[YW-1:0];
    endfunction

    assign w_sclk_rise = r_sclk_sh[1] & ~r_sclk_sh[2];

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_sclk_sh    <= '0;
            r_mosi_sh    <= '0;
            r_cs_sh      <= 2'b11;
            r_dc_sh      <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_byte       <= '0;
            r_byte_dc    <= 1'b0;
            r_byte_valid <= 1'b0;
        end else begin
            r_sclk_sh    <= {r_sclk_sh[1:0], i_sclk};
            r_mosi_sh    <= {r_mosi_sh[0], i_mosi};
            r_cs_sh      <= {r_cs_sh[0], i_cs};
            r_dc_sh      <= {r_dc_sh[0], i_dc};
            r_byte_valid <= 1'b0;
            if (r_cs_sh[1]) begin
                r_bit_cnt <= '0;
            end else if (w_sclk_rise) begin
                r_shift   <= {r_shift[5:0], r_mosi_sh[1]};
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    r_byte       <= {r_shift, r_mosi_sh[1]};
                    r_byte_dc    <= r_dc_sh[1];
                    r_byte_valid <= 1'b1;
                end
            end
        end
    end

    assign w_pix_fire = r_byte_valid & r_byte_dc & (r_state == c_st_ramwr_lo);
    assign w_win_done = r_byte_valid & r_byte_dc & (r_idx == 2'd3) &
                        ((r_state == c_st_caset) | (r_state == c_st_paset));

    // First three window bytes sit in r_par; the fourth is the current byte.
    assign w_xs_c   = clamp_x(r_par[23:8]);
    assign w_xe_c   = clamp_x({r_par[7:0], r_byte});
    assign w_xe_fix = (w_xs_c > w_xe_c) ? w_xs_c : w_xe_c;
    assign w_ys_c   = clamp_y(r_par[23:8]);
    assign w_ye_c   = clamp_y({r_par[7:0], r_byte});
    assign w_ye_fix = (w_ys_c > w_ye_c) ? w_ys_c : w_ye_c;

    always_comb begin
        w_state_nxt = r_state;
        if (r_byte_valid) begin
            if (!r_byte_dc) begin
                case (r_byte)
                    8'h2A:   w_state_nxt = c_st_caset;
                    8'h2B:   w_state_nxt = c_st_paset;
                    8'h2C:   w_state_nxt = c_st_ramwr_hi;
                    default: w_state_nxt = c_st_ignore;
                endcase
            end else begin
                case (r_state)
                    c_st_caset, c_st_paset: if (r_idx == 2'd3) w_state_nxt = c_st_idle;
                    c_st_ramwr_hi:          w_state_nxt = c_st_ramwr_lo;
                    c_st_ramwr_lo:          w_state_nxt = c_st_ramwr_hi;
                    default:                w_state_nxt = r_state;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= c_st_idle;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_idx       <= '0;
            r_par       <= '0;
            r_pix_hi    <= '0;
            r_xs        <= '0;
            r_xe        <= c_xmax[XW-1:0];
            r_ys        <= '0;
            r_ye        <= c_ymax[YW-1:0];
            r_cx        <= '0;
            r_cy        <= '0;
            r_pix_x     <= '0;
            r_pix_y     <= '0;
            r_pix_data  <= '0;
            r_pix_valid <= 1'b0;
        end else begin
            r_pix_valid <= w_pix_fire;
            if (r_byte_valid && !r_byte_dc) begin
                r_idx <= '0;
                if (r_byte == 8'h2C) begin
                    r_cx <= r_xs;
                    r_cy <= r_ys;
                end
            end else if (r_byte_valid) begin
                if ((r_state == c_st_caset) || (r_state == c_st_paset)) begin
                    r_par <= {r_par[15:0], r_byte};
                    r_idx <= r_idx + 2'd1;
                end
                if (r_state == c_st_ramwr_hi) r_pix_hi <= r_byte;
            end
            if (w_win_done) begin
                if (r_state == c_st_caset) begin
                    r_xs <= w_xs_c;
                    r_xe <= w_xe_fix;
                end else begin
                    r_ys <= w_ys_c;
                    r_ye <= w_ye_fix;
                end
            end
            if (w_pix_fire) begin
                r_pix_data <= {r_pix_hi, r_byte};
                r_pix_x    <= r_cx;
                r_pix_y    <= r_cy;
                if (r_cx == r_xe) begin
                    r_cx <= r_xs;
                    r_cy <= (r_cy == r_ye) ? r_ys : r_cy + YW'(1);
                end else begin
                    r_cx <= r_cx + XW'(1);
                end
            end
        end
    end

`ifdef SPI_LCD_RX_STATS_EN
    logic [31:0] r_pix_count;
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)                                  r_pix_count <= '0;
        else if (r_pix_valid && (r_pix_count != '1)) r_pix_count <= r_pix_count + 32'd1;
    end
    assign o_pix_count = r_pix_count;
`endif

    assign o_byte       = r_byte;
    assign o_byte_dc    = r_byte_dc;
    assign o_byte_valid = r_byte_valid;
    assign o_pix_valid  = r_pix_valid;
    assign o_pix_x      = r_pix_x;
    assign o_pix_y      = r_pix_y;
    assign o_pix_data   = r_pix_data;

endmodule

`default_nettype wire

// File: tb/tb_spi_lcd_rx.sv
// ============================================================================
// Module   : tb_spi_lcd_rx
// Brief    : Self-checking bench for spi_lcd_rx (table vectors, directed
//            corner sequences, randomized traffic vs. a byte-level model).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_lcd_rx;

    localparam int WIDTH  = 240;
    localparam int HEIGHT = 320;
    localparam int XW     = $clog2(WIDTH);
    localparam int YW     = $clog2(HEIGHT);

    logic i_clk = 1'b0, i_rst = 1'b0, i_sclk = 1'b0, i_mosi = 1'b0, i_cs = 1'b1, i_dc = 1'b0;
    logic [7:0]    o_byte;
    logic          o_byte_dc, o_byte_valid, o_pix_valid;
    logic [XW-1:0] o_pix_x;
    logic [YW-1:0] o_pix_y;
    logic [15:0]   o_pix_data;
`ifdef SPI_LCD_RX_STATS_EN
    logic [31:0]   o_pix_count;
`endif

    always #5 i_clk = ~i_clk;

    spi_lcd_rx #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_sclk(i_sclk), .i_mosi(i_mosi),
        .i_cs(i_cs), .i_dc(i_dc), .o_byte(o_byte), .o_byte_dc(o_byte_dc),
        .o_byte_valid(o_byte_valid), .o_pix_valid(o_pix_valid),
        .o_pix_x(o_pix_x), .o_pix_y(o_pix_y), .o_pix_data(o_pix_data)
`ifdef SPI_LCD_RX_STATS_EN
        , .o_pix_count(o_pix_count)
`endif
    );

    int n_checks = 0, n_fail = 0;
    logic [8:0]  obs_byte[$];
    logic [47:0] obs_pix[$], exp_pix[$];
    time t_bv = 0, t_rise = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge i_clk) begin
        if (o_byte_valid === 1'b1) begin
            obs_byte.push_back({o_byte_dc, o_byte});
            t_bv = $time;
        end
        if (o_pix_valid === 1'b1)
            obs_pix.push_back({16'(o_pix_x), 16'(o_pix_y), o_pix_data});
    end

    // Byte-level reference model of the display command decoder.
    int m_st, m_idx, m_buf[4], m_xs, m_xe, m_ys, m_ye, m_cx, m_cy, m_hi, m_count;

    function automatic void model_reset();
        m_st = 0; m_idx = 0; m_xs = 0; m_xe = WIDTH - 1; m_ys = 0; m_ye = HEIGHT - 1;
        m_cx = 0; m_cy = 0; m_hi = 0; m_count = 0;
    endfunction

    function automatic void model_byte(input logic dc, input logic [7:0] b);
        int s, e;
        if (!dc) begin
            m_idx = 0;
            case (b)
                8'h2A:   m_st = 1;
                8'h2B:   m_st = 2;
                8'h2C:   begin m_st = 3; m_cx = m_xs; m_cy = m_ys; end
                default: m_st = 5;
            endcase
        end else if (m_st == 1 || m_st == 2) begin
            m_buf[m_idx] = int'(b);
            m_idx++;
            if (m_idx == 4) begin
                s = m_buf[0] * 256 + m_buf[1];
                e = m_buf[2] * 256 + m_buf[3];
                if (m_st == 1) begin
                    if (s > WIDTH - 1) s = WIDTH - 1;
                    if (e > WIDTH - 1) e = WIDTH - 1;
                    if (s > e) e = s;
                    m_xs = s; m_xe = e;
                end else begin
                    if (s > HEIGHT - 1) s = HEIGHT - 1;
                    if (e > HEIGHT - 1) e = HEIGHT - 1;
                    if (s > e) e = s;
                    m_ys = s; m_ye = e;
                end
                m_st = 0;
            end
        end else if (m_st == 3) begin
            m_hi = int'(b);
            m_st = 4;
        end else if (m_st == 4) begin
            exp_pix.push_back({16'(m_cx), 16'(m_cy), 16'(m_hi * 256 + int'(b))});
            if (m_count != 32'hFFFF_FFFF) m_count++;
            if (m_cx == m_xe) begin
                m_cx = m_xs;
                m_cy = (m_cy == m_ye) ? m_ys : m_cy + 1;
            end else begin
                m_cx++;
            end
            m_st = 3;
        end
    endfunction

    // Called right after a negedge; every SCLK change lands on a negedge.
    task automatic spi_bits(input logic dc, input logic [7:0] b, input int n);
        i_dc = dc;
        for (int i = 7; i > 7 - n; i--) begin
            i_mosi = b[i];
            #40 i_sclk = 1'b1;
            if (i == 0) t_rise = $time;
            #40 i_sclk = 1'b0;
        end
    endtask

    task automatic send(input logic dc, input logic [7:0] b);
        spi_bits(dc, b, 8);
        model_byte(dc, b);
    endtask

    task automatic settle();
        repeat (8) @(negedge i_clk);
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b1;
        model_reset();
        repeat (4) @(negedge i_clk);
        obs_pix.delete();
        obs_byte.delete();
        exp_pix.delete();
    endtask

    task automatic check_pixels(input string name);
        logic [47:0] e;
        while (exp_pix.size() > 0) begin
            e = exp_pix.pop_front();
            if (obs_pix.size() == 0) check({name, "_missing"}, 64'd0, {16'd0, e});
            else                     check(name, obs_pix.pop_front(), e);
        end
        check({name, "_extra"}, obs_pix.size(), 0);
        obs_pix.delete();
    endtask

    typedef struct {
        logic       dc;
        logic [7:0] b;
        logic       exp_dc;
        logic [7:0] exp_b;
    } vec_t;

    vec_t tbl[6];
    int   ex[8], ey[8];
    logic [47:0] p;

    initial begin
        tbl[0] = '{1'b1, 8'hA5, 1'b1, 8'hA5};
        tbl[1] = '{1'b0, 8'h3C, 1'b0, 8'h3C};
        tbl[2] = '{1'b1, 8'hFF, 1'b1, 8'hFF};
        tbl[3] = '{1'b1, 8'h00, 1'b1, 8'h00};
        tbl[4] = '{1'b0, 8'h81, 1'b0, 8'h81};
        tbl[5] = '{1'b1, 8'h5A, 1'b1, 8'h5A};

        repeat (3) @(negedge i_clk);
        check("rst_byte", o_byte, 0);
        check("rst_byte_dc", o_byte_dc, 0);
        check("rst_byte_valid", o_byte_valid, 0);
        check("rst_pix_valid", o_pix_valid, 0);
        check("rst_pix_xy", {o_pix_x, o_pix_y}, 0);
        check("rst_pix_data", o_pix_data, 0);
        i_rst = 1'b1;
        model_reset();
        @(negedge i_clk);
        i_cs = 1'b0;
        repeat (4) @(negedge i_clk);

        foreach (tbl[i]) begin
            obs_byte.delete();
            send(tbl[i].dc, tbl[i].b);
            repeat (4) @(negedge i_clk);
            check("tbl_strobe_count", obs_byte.size(), 1);
            if (obs_byte.size() > 0)
                check("tbl_byte", obs_byte.pop_front(), {tbl[i].exp_dc, tbl[i].exp_b});
            check("tbl_latency", (t_bv - t_rise) <= 40, 1);
            repeat (6) @(negedge i_clk);
            check("tbl_hold", {o_byte_dc, o_byte}, {tbl[i].exp_dc, tbl[i].exp_b});
        end
        check_pixels("tbl_pix");

        // Window 5..7 x 2..3, eight red pixels wrap back to the start.
        ex = '{5, 6, 7, 5, 6, 7, 5, 6};
        ey = '{2, 2, 2, 3, 3, 3, 2, 2};
        send(0, 8'h2A); send(1, 8'h00); send(1, 8'h05); send(1, 8'h00); send(1, 8'h07);
        send(0, 8'h2B); send(1, 8'h00); send(1, 8'h02); send(1, 8'h00); send(1, 8'h03);
        send(0, 8'h2C);
        for (int i = 0; i < 8; i++) begin send(1, 8'hF8); send(1, 8'h00); end
        settle();
        check("win_count", obs_pix.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (obs_pix.size() > 0) begin
                p = obs_pix.pop_front();
                check("win_pix", p, {16'(ex[i]), 16'(ey[i]), 16'hF800});
            end
        end
        check("pix_hold", {16'(o_pix_x), 16'(o_pix_y), o_pix_data}, {16'd6, 16'd2, 16'hF800});
        exp_pix.delete();
        obs_pix.delete();

        // Partial byte aborted by CS.
        obs_byte.delete();
        spi_bits(1, 8'hFF, 5);
        #40 i_cs = 1'b1;
        #80 i_cs = 1'b0;
        #40;
        send(1, 8'h3C);
        settle();
        check("partial_count", obs_byte.size(), 1);
        if (obs_byte.size() > 0) check("partial_byte", obs_byte.pop_front(), {1'b1, 8'h3C});

        // Column clamp to WIDTH-1.
        do_reset();
        send(0, 8'h2A); send(1, 8'h01); send(1, 8'h00); send(1, 8'h01); send(1, 8'hFF);
        send(0, 8'h2C); send(1, 8'h12); send(1, 8'h34); send(1, 8'h56); send(1, 8'h78);
        settle();
        check("clamp_count", obs_pix.size(), 2);
        if (obs_pix.size() > 1) begin
            check("clamp_pix0", obs_pix.pop_front(), {16'd239, 16'd0, 16'h1234});
            check("clamp_pix1", obs_pix.pop_front(), {16'd239, 16'd1, 16'h5678});
        end
        exp_pix.delete();
        obs_pix.delete();

        // Command during RAMWR_LO drops the pixel; following data is ignored.
        send(0, 8'h2C); send(1, 8'h12); send(0, 8'h00); send(1, 8'h34); send(1, 8'h56);
        settle();
        check("abort_no_pix", obs_pix.size(), 0);
        check_pixels("abort_model");

        // Reset in the middle of a RAMWR.
        send(0, 8'h2C); send(1, 8'hAB);
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        check("midrst_byte", {o_byte_dc, o_byte, o_byte_valid}, 0);
        check("midrst_pix", {o_pix_valid, o_pix_x, o_pix_y, o_pix_data}, 0);
        repeat (3) @(negedge i_clk);
        i_rst = 1'b1;
        model_reset();
        exp_pix.delete();
        obs_pix.delete();
        repeat (4) @(negedge i_clk);
        send(0, 8'h2C); send(1, 8'h00); send(1, 8'h1F); send(1, 8'h07); send(1, 8'hE0);
        settle();
        check("fullwin_count", obs_pix.size(), 2);
        if (obs_pix.size() > 1) begin
            check("fullwin_pix0", obs_pix.pop_front(), {16'd0, 16'd0, 16'h001F});
            check("fullwin_pix1", obs_pix.pop_front(), {16'd1, 16'd0, 16'h07E0});
        end
        exp_pix.delete();
        obs_pix.delete();

        // 100-pixel burst.
        do_reset();
        send(0, 8'h2C);
        for (int i = 0; i < 100; i++) begin
            send(1, 8'($urandom)); send(1, 8'($urandom));
        end
        settle();
`ifdef SPI_LCD_RX_STATS_EN
        check("pix_count_100", o_pix_count, 100);
`endif
        check_pixels("burst_pix");

        // Randomized command/data traffic against the model.
        for (int t = 0; t < 40; t++) begin
            int kind, n;
            kind = $urandom_range(0, 7);
            n = $urandom_range(0, 5);
            if (kind <= 1) begin
                send(0, kind == 0 ? 8'h2A : 8'h2B);
                for (int k = 0; k < n; k++)
                    send(1, (k % 2 == 0) ? (($urandom_range(0, 5) == 0) ? 8'h01 : 8'h00)
                                         : 8'($urandom_range(0, 255)));
            end else if (kind <= 4) begin
                send(0, 8'h2C);
                for (int k = 0; k < 2 * n + $urandom_range(0, 1); k++) send(1, 8'($urandom));
            end else if (kind == 5) begin
                send(0, 8'($urandom));
                send(1, 8'($urandom));
            end else begin
                #40 i_cs = 1'b1;
                #80 i_cs = 1'b0;
                #40;
                send(1, 8'($urandom));
            end
        end
        settle();
`ifdef SPI_LCD_RX_STATS_EN
        check("pix_count_rand", o_pix_count, m_count);
`endif
        check_pixels("rand_pix");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
